// File: rtl/adbg_ahb3_xfer_pkg.sv
// Shared definitions for the adbg AHB3-Lite single-transfer engine.
// Holds the AHB encodings, the engine state type, request legality,
// the size-to-HSIZE mapping and the byte-lane placement helpers.
// The lane helpers always work on 64-bit vectors. Callers truncate
// the result to their own data width.
package adbg_ahb3_xfer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    // Data access, privileged, non-bufferable, non-cacheable
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } xfer_state_e;

    // Byte count (1/2/4/8) to AHB HSIZE encoding
    function automatic logic [2:0] size_to_hsize(input logic [3:0] size);
        logic [2:0] hsize;
        case (size)
            4'd1:    hsize = HSIZE_BYTE;
            4'd2:    hsize = HSIZE_HWORD;
            4'd4:    hsize = HSIZE_WORD;
            4'd8:    hsize = HSIZE_DWORD;
            default: hsize = HSIZE_BYTE;
        endcase
        return hsize;
    endfunction

    // Size must be a supported byte count and the address naturally aligned.
    // Eight-byte transfers exist only on a 64-bit bus.
    function automatic logic request_legal(input logic [3:0] size,
                                           input logic [2:0] addr_lo,
                                           input logic       dw64);
        logic ok;
        case (size)
            4'd1:    ok = 1'b1;
            4'd2:    ok = (addr_lo[0] == 1'b0);
            4'd4:    ok = (addr_lo[1:0] == 2'b00);
            4'd8:    ok = dw64 && (addr_lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Mask of the low-order bytes covered by one transfer of the given HSIZE
    function automatic logic [63:0] size_mask(input logic [2:0] hsize);
        logic [63:0] mask;
        case (hsize)
            HSIZE_BYTE:  mask = 64'h0000_0000_0000_00FF;
            HSIZE_HWORD: mask = 64'h0000_0000_0000_FFFF;
            HSIZE_WORD:  mask = 64'h0000_0000_FFFF_FFFF;
            HSIZE_DWORD: mask = 64'hFFFF_FFFF_FFFF_FFFF;
            default:     mask = 64'h0000_0000_0000_0000;
        endcase
        return mask;
    endfunction

    // Right-justified data moved up onto its byte lanes. Bytes outside the
    // transfer are zero.
    function automatic logic [63:0] lane_place(input logic [63:0] data,
                                               input logic [2:0]  off,
                                               input logic [2:0]  hsize);
        return (data & size_mask(hsize)) << {off, 3'b000};
    endfunction

    // Lane data brought down to bit 0. Bytes above the transfer size are cleared.
    function automatic logic [63:0] lane_extract(input logic [63:0] data,
                                                 input logic [2:0]  off,
                                                 input logic [2:0]  hsize);
        return (data >> {off, 3'b000}) & size_mask(hsize);
    endfunction

endpackage

// File: rtl/adbg_ahb3_xfer_if.sv
// Request/response and AHB3-Lite master signal bundle for adbg_ahb3_xfer.
// The master modport is the engine's view: it accepts req_*, produces rsp_*,
// drives the AHB master outputs and receives HRDATA/HREADY/HRESP.
// The slave modport is the surrounding environment's view.
interface adbg_ahb3_xfer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [3:0]            req_size_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;

    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_size_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_size_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/adbg_ahb3_xfer.sv
// HCLK-domain AHB3-Lite single-transfer master for the advanced debug
// interface. It takes one request at a time and runs the address and data
// phases, honouring HREADY wait states and the two-cycle error response.
// It returns right-justified read data and an error flag on a one-cycle strobe.
// Ports:
//   HCLK    - bus clock, sole clock of the block
//   HRESETn - asynchronous active-low reset
//   bus     - adbg_ahb3_xfer_if.master: req_* in and req_ready_o out,
//             rsp_* out, AHB master outputs, and HRDATA/HREADY/HRESP in
// All outputs come straight from flops. Illegal requests (bad size or
// misaligned address) are answered with an error and never reach the bus.
module adbg_ahb3_xfer
    import adbg_ahb3_xfer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    adbg_ahb3_xfer_if.master  bus
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam bit DW64  = (DATA_WIDTH == 64);

    xfer_state_e           state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hsel_q, hsel_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic [2:0]            off_q, off_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  accept_s;
    logic                  legal_s;
    logic [2:0]            off_s;
    logic [2:0]            req_hsize_s;

    // req_ready_q is high exactly while IDLE, so this also ignores req_* elsewhere
    assign accept_s    = bus.req_valid_i && req_ready_q;
    assign legal_s     = request_legal(bus.req_size_i, bus.req_addr_i[2:0], DW64);
    assign off_s       = 3'(bus.req_addr_i[OFF_W-1:0]);
    assign req_hsize_s = size_to_hsize(bus.req_size_i);

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && legal_s) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                // HREADY high ends the transfer whether HRESP flags OKAY or a
                // single-cycle error. HRESP with HREADY low opens the error response.
                if (bus.HREADY) begin
                    state_d = ST_IDLE;
                end else if (bus.HRESP) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR: begin
                if (bus.HREADY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        htrans_d    = htrans_q;
        hsel_d      = hsel_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        off_d       = off_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && legal_s) begin
                    htrans_d = HTRANS_NONSEQ;
                    hsel_d   = 1'b1;
                    haddr_d  = bus.req_addr_i;
                    hwrite_d = bus.req_write_i;
                    hsize_d  = req_hsize_s;
                    off_d    = off_s;
                    // Loaded now so that HWDATA is already stable when the data phase opens
                    hwdata_d = DATA_WIDTH'(lane_place(64'(bus.req_wdata_i), off_s, req_hsize_s));
                end else if (accept_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    htrans_d = HTRANS_IDLE;
                    hsel_d   = 1'b0;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    hsel_d   = 1'b0;
                end else begin
                    htrans_d = HTRANS_NONSEQ;
                    hsel_d   = 1'b1;
                end
            end
            ST_DATA: begin
                if (bus.HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.HRESP;
                    if (bus.HRESP || hwrite_q) begin
                        rsp_rdata_d = '0;
                    end else begin
                        rsp_rdata_d = DATA_WIDTH'(lane_extract(64'(bus.HRDATA), off_q, hsize_q));
                    end
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            ST_ERR: begin
                if (bus.HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                htrans_d = HTRANS_IDLE;
                hsel_d   = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            req_ready_q <= 1'b1;
            htrans_q    <= HTRANS_IDLE;
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hwdata_q    <= '0;
            off_q       <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= req_ready_d;
            htrans_q    <= htrans_d;
            hsel_q      <= hsel_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            off_q       <= off_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.HSEL        = hsel_q;
    assign bus.HADDR       = haddr_q;
    assign bus.HWDATA      = hwdata_q;
    assign bus.HWRITE      = hwrite_q;
    assign bus.HSIZE       = hsize_q;
    assign bus.HTRANS      = htrans_q;
    assign bus.HBURST      = HBURST_SINGLE;
    assign bus.HPROT       = HPROT_DEFAULT;
    assign bus.HMASTLOCK   = 1'b0;

endmodule

// File: tb/tb_adbg_ahb3_xfer.sv
// Testbench for adbg_ahb3_xfer (32-bit address and data). A byte-addressed
// reference memory predicts every response when a request is issued. A
// slave process models an AHB memory with planned wait states and errors.
// A monitor pops the expected responses and compares them, including the
// response cycle.
module tb_adbg_ahb3_xfer;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    adbg_ahb3_xfer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    adbg_ahb3_xfer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int          aw;     // address-phase wait states
        int          dw;     // data-phase wait states
        int          et;     // 0 OKAY, 1 two-cycle error, 2 error with HREADY high
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  size;
        logic [31:0] wdata;
    } plan_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    plan_t       plans[$];
    exp_t        exps[$];
    plan_t       sp;
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [7:0]  smem [256];
    logic [7:0]  mmem [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int mi(input logic [31:0] a, input int i);
        return (int'(a[7:0]) + i) % 256;
    endfunction

    function automatic logic [2:0] log2_size(input logic [3:0] s);
        return (s == 4'd1) ? 3'd0 : (s == 4'd2) ? 3'd1 : (s == 4'd4) ? 3'd2 : 3'd3;
    endfunction

    // Write data expected on HWDATA: request bytes on lanes starting at addr%4
    function automatic logic [31:0] exp_hwdata(input plan_t p);
        logic [31:0] r;
        int off;
        r = 32'h0;
        off = int'(p.addr[1:0]);
        for (int i = 0; i < int'(p.size); i++) r[8*(off+i) +: 8] = p.wdata[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] base;
        base = a & 32'hFFFF_FFFC;
        return {smem[mi(base, 3)], smem[mi(base, 2)], smem[mi(base, 1)], smem[mi(base, 0)]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (bus.rsp_valid_o === 1'b1) begin
            if (exps.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exps.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("rsp_err", 64'(bus.rsp_err_o), 64'(mon_e.err));
                if (!mon_e.err) chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(mon_e.rdata));
            end
        end
    end

    // AHB slave model: memory with planned wait states and error responses
    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.HTRANS == 2'b10) begin
                chk("plan_avail", 64'(plans.size() != 0), 64'd1);
                if (plans.size() != 0) begin
                    sp = plans.pop_front();
                    chk("HADDR", 64'(bus.HADDR), 64'(sp.addr));
                    chk("HWRITE", 64'(bus.HWRITE), 64'(sp.wr));
                    chk("HSIZE", 64'(bus.HSIZE), 64'(log2_size(sp.size)));
                    chk("HSEL_addr", 64'(bus.HSEL), 64'd1);
                    chk("HBURST", 64'(bus.HBURST), 64'd0);
                    chk("HPROT", 64'(bus.HPROT), 64'd3);
                    chk("HMASTLOCK", 64'(bus.HMASTLOCK), 64'd0);
                    for (int i = 0; i < sp.aw; i++) begin
                        bus.HREADY = 1'b0;
                        @(negedge clk);
                        chk("HTRANS_addr_wait", 64'(bus.HTRANS), 64'd2);
                        chk("HADDR_addr_wait", 64'(bus.HADDR), 64'(sp.addr));
                    end
                    bus.HREADY = 1'b1;
                    @(negedge clk);
                    chk("HTRANS_data", 64'(bus.HTRANS), 64'd0);
                    chk("HSEL_data", 64'(bus.HSEL), 64'd0);
                    if (sp.wr && rst_n) chk("HWDATA", 64'(bus.HWDATA), 64'(exp_hwdata(sp)));
                    for (int i = 0; i < sp.dw; i++) begin
                        bus.HREADY = 1'b0;
                        @(negedge clk);
                        chk("HTRANS_data_wait", 64'(bus.HTRANS), 64'd0);
                    end
                    if (sp.et == 1) begin
                        bus.HREADY = 1'b0;
                        bus.HRESP  = 1'b1;
                        @(negedge clk);
                        chk("HTRANS_err", 64'(bus.HTRANS), 64'd0);
                        bus.HREADY = 1'b1;
                        @(negedge clk);
                    end else if (sp.et == 2) begin
                        bus.HREADY = 1'b1;
                        bus.HRESP  = 1'b1;
                        @(negedge clk);
                    end else begin
                        bus.HREADY = 1'b1;
                        bus.HRESP  = 1'b0;
                        bus.HRDATA = mem_word(sp.addr);
                        if (sp.wr && rst_n) begin
                            chk("HWDATA_end", 64'(bus.HWDATA), 64'(exp_hwdata(sp)));
                            for (int i = 0; i < int'(sp.size); i++)
                                smem[mi(sp.addr, i)] = bus.HWDATA[8*(int'(sp.addr[1:0])+i) +: 8];
                        end
                        @(negedge clk);
                    end
                    bus.HREADY = 1'b1;
                    bus.HRESP  = 1'b0;
                    bus.HRDATA = 32'h0;
                end
            end
        end
    end

    // Issue one request at a negedge; the reference model predicts its response
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] size,
                         input logic [31:0] wdata, input int aw, input int dw,
                         input int et, input bit want_rsp);
        bit    legal;
        int    n;
        int    budget;
        plan_t p;
        exp_t  e;
        legal = 1'b0;
        if (size == 4'd1 || size == 4'd2 || size == 4'd4) legal = ((addr % size) == 0);
        budget = 0;
        while (bus.req_ready_o !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_wait", 64'(budget < 100), 64'd1);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = wr;
        bus.req_addr_i  = addr;
        bus.req_size_i  = size;
        bus.req_wdata_i = wdata;
        n = cyc;
        e.rdata = 32'h0;
        if (legal) begin
            p.aw = aw; p.dw = dw; p.et = et; p.addr = addr; p.wr = wr; p.size = size; p.wdata = wdata;
            plans.push_back(p);
            e.err = (et != 0);
            e.cyc = n + 3 + aw + dw + ((et == 1) ? 1 : 0);
            if (et == 0) begin
                for (int i = 0; i < int'(size); i++) begin
                    if (wr) mmem[mi(addr, i)] = wdata[8*i +: 8];
                    else    e.rdata[8*i +: 8] = mmem[mi(addr, i)];
                end
            end
        end else begin
            e.err = 1'b1;
            e.cyc = n + 1;
        end
        if (want_rsp) exps.push_back(e);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          budget;
        logic [3:0]  sizes [10];
        logic [3:0]  sz;
        logic [31:0] a;
        int          r;
        int          et;
        sizes = '{4'd1, 4'd2, 4'd4, 4'd1, 4'd2, 4'd4, 4'd4, 4'd3, 4'd8, 4'd0};
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'($urandom);
            mmem[i] = smem[i];
        end
        smem[0] = 8'hD4; smem[1] = 8'hC3; smem[2] = 8'hB2; smem[3] = 8'hA1;
        mmem[0] = 8'hD4; mmem[1] = 8'hC3; mmem[2] = 8'hB2; mmem[3] = 8'hA1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = 32'h0;
        bus.req_size_i  = 4'd0;
        bus.req_wdata_i = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_htrans", 64'(bus.HTRANS), 64'd0);
        chk("rst_hsel", 64'(bus.HSEL), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err_o), 64'd0);
        chk("rst_haddr", 64'(bus.HADDR), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        issue(1'b1, 32'h0000_0104, 4'd2, 32'h0000_BEEF, 0, 0, 0, 1'b1);
        issue(1'b0, 32'h0000_0203, 4'd1, 32'h0, 0, 0, 0, 1'b1);
        issue(1'b0, 32'h0000_1000, 4'd4, 32'h0, 2, 3, 0, 1'b1);
        issue(1'b1, 32'h0000_0010, 4'd4, 32'hCAFE_F00D, 0, 0, 1, 1'b1);
        issue(1'b0, 32'h0000_0020, 4'd2, 32'h0, 1, 1, 2, 1'b1);
        issue(1'b1, 32'h0000_0102, 4'd4, 32'h1234_5678, 0, 0, 0, 1'b1);
        chk("misaligned_htrans", 64'(bus.HTRANS), 64'd0);
        issue(1'b0, 32'h0000_0104, 4'd2, 32'h0, 0, 0, 0, 1'b1);

        // Reset during the data phase drops the transfer silently
        repeat (3) @(negedge clk);
        issue(1'b0, 32'h0000_0020, 4'd4, 32'h0, 0, 6, 0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_htrans", 64'(bus.HTRANS), 64'd0);
        chk("async_rst_ready", 64'(bus.req_ready_o), 64'd1);
        chk("async_rst_haddr", 64'(bus.HADDR), 64'd0);
        chk("async_rst_hwrite", 64'(bus.HWRITE), 64'd0);
        chk("async_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(1'b1, 32'h0000_0040, 4'd4, 32'h1357_9BDF, 0, 0, 0, 1'b1);
        issue(1'b0, 32'h0000_0042, 4'd2, 32'h0, 0, 0, 0, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 80; k++) begin
            sz = sizes[$urandom_range(0, 9)];
            a  = $urandom;
            if ((sz == 4'd1 || sz == 4'd2 || sz == 4'd4) && $urandom_range(0, 3) != 0)
                a = a - (a % sz);
            r  = $urandom_range(0, 9);
            et = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            issue(1'($urandom_range(0, 1)), a, sz, $urandom,
                  $urandom_range(0, 2), $urandom_range(0, 2), et, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        budget = 0;
        while (exps.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_rsp", 64'(exps.size()), 64'd0);
        chk("drain_plans", 64'(plans.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adbg_ahb3_xfer.md
# adbg_ahb3_xfer

HCLK-domain AHB3-Lite single-transfer master engine for the advanced debug interface AHB3 path. It sits directly downstream of the debug bus interface unit's clock-domain crossing and takes one synchronized request at a time: address, size, direction and right-justified write data. It runs the AHB3-Lite address and data phases, inserting wait states on HREADY and handling the two-cycle HRESP error response. It returns right-justified read data plus an error flag on a one-cycle response strobe.

## Interface
- ADDR_WIDTH, 32, HADDR and request address width
- DATA_WIDTH, 32, HWDATA/HRDATA width; legal values 32 or 64
- HCLK  in  1  bus clock; sole clock of the block
- HRESETn  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  engine can accept; high only in IDLE
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  byte address
- req_size_i  in  4  transfer size in bytes: 1, 2, 4, or 8 (8 only if DATA_WIDTH=64)
- req_wdata_i  in  DATA_WIDTH  right-justified write data
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_rdata_o  out  DATA_WIDTH  right-justified read data, upper bytes zero; 0 for writes
- rsp_err_o  out  1  bus error or illegal request; valid with rsp_valid_o
- HSEL, HADDR, HWDATA, HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HTRANS[1:0], HMASTLOCK  out  AHB3-Lite master outputs
- HRDATA, HREADY, HRESP  in  AHB3-Lite master inputs

## Operation
- States: IDLE, ADDR, DATA, ERR.
- IDLE: req_ready_o=1. req_valid_i&&req_ready_o accepts the request and registers it.
  - Legal request → ADDR.
  - Illegal request (size not in legal set, or addr not size-aligned) → no bus transfer; rsp_valid_o=1, rsp_err_o=1 next cycle; stays IDLE.
- ADDR: HTRANS=NONSEQ, HSEL=1, HADDR, HWRITE and HSIZE (log2 of size) held stable. HREADY=1 → DATA. HREADY=0 → hold.
- DATA: HTRANS=IDLE, HSEL=0; HWDATA held stable for the whole phase.
  - HREADY=1, HRESP=0 → capture read data, respond OKAY, → IDLE.
  - HRESP=1 with HREADY=0 → ERR.
- ERR: waits for HREADY=1 with HRESP=1, then responds rsp_err_o=1 → IDLE. HRESP=1 seen together with HREADY=1 in DATA is also an error.
- Lane placement: off = addr[log2(DATA_WIDTH/8)-1:0].
  - HWDATA = wdata << 8*off; unused lanes 0.
  - rsp_rdata_o = (HRDATA >> 8*off) masked to size bytes.
- Constants: HBURST=SINGLE (000), HPROT=4'b0011 (data, privileged, non-bufferable, non-cacheable), HMASTLOCK=0.
- No response backpressure: the consumer always samples rsp_* on rsp_valid_o.

## Timing
- Reset values: all outputs 0 except req_ready_o=1. This gives HTRANS=IDLE, HSEL=0, rsp_valid_o=0. State is IDLE.
- Zero-wait latency:
  - accept at cycle n
  - NONSEQ on bus n+1
  - data phase n+2
  - rsp_valid_o n+3
- Each address or data wait state adds one cycle.
- rsp_valid_o and the return to IDLE happen in the same cycle. A new request can be accepted in that cycle, giving NONSEQ at +1. Minimum period is 3 cycles per zero-wait transfer.
- All AHB outputs and rsp_* are registered. rsp_rdata_o/rsp_err_o hold until the next response.
- HRESETn asserted mid-transfer forces all outputs to reset values immediately. The in-flight transfer is dropped with no response.
- req_* inputs are ignored outside IDLE.

## Structure
- adbg_ahb3_pkg additions:
  - HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HPROT_DEFAULT constants
  - HSIZE_BYTE/HWORD/WORD/DWORD encodings
  - state enum
  - size-to-HSIZE function
  - lane-shift helper functions
- Single flat module; no sub-module.

## Test plan
- Write, addr 0x104, size 2, wdata 0x0000BEEF, zero wait:
  - HSIZE=001, HADDR=0x104, HWDATA=0x0000BEEF
  - rsp_valid_o at n+3, rsp_err_o=0
- Read, addr 0x203, size 1, HRDATA=0xA1B2C3D4:
  - rsp_rdata_o=0x000000A1
- Read, addr 0x1000, size 4, HREADY low 2 cycles in ADDR and 3 cycles in DATA:
  - HADDR/HTRANS stable while waiting
  - rsp_valid_o at n+8
- HRESP=1,HREADY=0 then HRESP=1,HREADY=1 in DATA:
  - HTRANS=IDLE during the error cycles
  - rsp_err_o=1, single rsp_valid_o pulse
- Misaligned write, addr 0x102, size 4:
  - HTRANS stays IDLE
  - rsp_valid_o at n+1 with rsp_err_o=1
- HRESETn low during DATA:
  - outputs return to reset values asynchronously, no rsp_valid_o
  - next request completes normally
